// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter and its environment.
//   cpu_*  : CPU data port (address/write data/write enable in; read data,
//            hold and collision flag out)
//   host_* : host burst port (request/direction/base/length/write word in;
//            read word, ack, word index and done pulse out)
//   mem_*  : single-port dmem (address/write data/write enable out;
//            asynchronous read data in)
// slave  : view taken by dmem_arbiter
// master : view taken by the CPU/host/memory side
interface dmem_arbiter_if;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_we;
  logic [15:0] cpu_rdata;
  logic        cpu_hold;
  logic        cpu_collision;

  logic        host_req;
  logic        host_we;
  logic [7:0]  host_addr;
  logic [3:0]  host_len;
  logic [15:0] host_wdata;
  logic [15:0] host_rdata;
  logic        host_ack;
  logic [3:0]  host_idx;
  logic        host_done;

  logic [7:0]  mem_addr;
  logic [15:0] mem_data;
  logic        mem_we;
  logic [15:0] mem_q;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we,
    output cpu_rdata, cpu_hold, cpu_collision,
    input  host_req, host_we, host_addr, host_len, host_wdata,
    output host_rdata, host_ack, host_idx, host_done,
    output mem_addr, mem_data, mem_we,
    input  mem_q
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_we,
    input  cpu_rdata, cpu_hold, cpu_collision,
    output host_req, host_we, host_addr, host_len, host_wdata,
    input  host_rdata, host_ack, host_idx, host_done,
    input  mem_addr, mem_data, mem_we,
    output mem_q
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port dmem between a CPU and a
// burst-oriented host. On a host request the CPU is frozen (cpu_hold) for
// HOLD_CYCLES drain cycles, the host then moves len+1 consecutive words
// starting at its base address (wrapping at 0xFF), and afterwards the CPU
// owns the memory for at least MIN_GAP cycles.
//   clock, reset : single clock, synchronous active-high reset
//   bus          : dmem_arbiter_if.slave (CPU, host and dmem signals)
// Parameters:
//   HOLD_CYCLES  : CPU freeze cycles before the first host word (1..7)
//   MIN_GAP      : CPU ownership cycles after each host burst (1..15)
module dmem_arbiter #(
  parameter int unsigned HOLD_CYCLES = 1,
  parameter int unsigned MIN_GAP     = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  dmem_arbiter_if.slave        bus
);

  typedef enum logic [1:0] {IDLE, DRAIN, XFER, GAP} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] GAP_LAST  = 4'(MIN_GAP - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [3:0]  idx;
  logic [7:0]  base;
  logic [3:0]  len;
  logic        we_lat;
  logic        hold;
  logic        collision;

  logic        owned;
  logic        xfer_live;
  logic        last_word;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      base      <= '0;
      len       <= '0;
      we_lat    <= 1'b0;
      hold      <= 1'b0;
      collision <= 1'b0;
    end else begin
      // A CPU write while frozen is dropped at the memory mux; remember it.
      if (hold && bus.cpu_we)
        collision <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.host_req) begin
            base   <= bus.host_addr;
            len    <= bus.host_len;
            we_lat <= bus.host_we;
            idx    <= '0;
            cnt    <= '0;
            hold   <= 1'b1;
            state  <= DRAIN;
          end
        end
        DRAIN: begin
          if (!bus.host_req) begin
            cnt   <= '0;
            hold  <= 1'b0;
            state <= GAP;
          end else if (cnt == HOLD_LAST) begin
            cnt   <= '0;
            state <= XFER;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        XFER: begin
          // idx is left untouched on exit so it reports the words moved.
          if (!bus.host_req || idx == len) begin
            cnt   <= '0;
            hold  <= 1'b0;
            state <= GAP;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST)
            state <= IDLE;
          else
            cnt <= cnt + 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Host-side effects are suppressed during a reset cycle so a burst
  // killed by reset never shows an ack, a done pulse or a final write.
  always_comb begin
    owned     = (state == DRAIN) || (state == XFER);
    last_word = (idx == len);
    xfer_live = (state == XFER) && bus.host_req && !reset;

    bus.host_ack  = xfer_live;
    bus.host_done = !reset && owned &&
                    (!bus.host_req || ((state == XFER) && last_word));

    if (owned) begin
      bus.mem_addr = base + {4'b0000, idx};
      bus.mem_data = bus.host_wdata;
      bus.mem_we   = xfer_live && we_lat;
    end else begin
      bus.mem_addr = bus.cpu_addr;
      bus.mem_data = bus.cpu_wdata;
      bus.mem_we   = bus.cpu_we;
    end
  end

  assign bus.cpu_rdata     = bus.mem_q;
  assign bus.host_rdata    = bus.mem_q;
  assign bus.host_idx      = idx;
  assign bus.cpu_hold      = hold;
  assign bus.cpu_collision = collision;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 1: CPU freeze cycles before the first host access (legal values 1..7).
REQ-002 SHALL have parameter MIN_GAP, default 4: cycles of guaranteed CPU ownership after each host burst (legal values 1..15).
REQ-003 clock  input  1  single clock; all state changes on posedge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 cpu_addr  input  8  CPU data address.
REQ-006 cpu_wdata  input  16  CPU write data.
REQ-007 cpu_we  input  1  CPU write enable.
REQ-008 cpu_rdata  output  16  CPU read data, equals mem_q at all times.
REQ-009 cpu_hold  output  1  high freezes CPU; drives the CPU enable inverted.
REQ-010 cpu_collision  output  1  sticky flag: a CPU write was dropped.
REQ-011 host_req  input  1  host burst request; held high until host_done.
REQ-012 host_we  input  1  burst direction, 1 = write; sampled at grant.
REQ-013 host_addr  input  8  burst base address; sampled at grant.
REQ-014 host_len  input  4  burst length minus one (1..16 words); sampled at grant.
REQ-015 host_wdata  input  16  write word for the current host_idx.
REQ-016 host_rdata  output  16  read word, equals mem_q; valid while host_ack is high.
REQ-017 host_ack  output  1  high for each cycle one host word is transferred.
REQ-018 host_idx  output  4  word index of the current transfer, 0-based.
REQ-019 host_done  output  1  one-cycle pulse ending a burst.
REQ-020 mem_addr, mem_data, mem_we  output  8/16/1  single-port dmem address, write data and write enable.
REQ-021 mem_q  input  16  dmem asynchronous read data.

Function
REQ-022 SHALL implement states IDLE, DRAIN, XFER and GAP; cpu_hold SHALL be high exactly in DRAIN and XFER.
REQ-023 IDLE and GAP: mem_addr=cpu_addr, mem_data=cpu_wdata, mem_we=cpu_we.
REQ-024 IDLE with host_req=1 at a posedge: SHALL latch host_addr, host_len and host_we, clear host_idx, and enter DRAIN.
REQ-025 DRAIN: mem_we=0 and host_ack=0 for exactly HOLD_CYCLES cycles, then enter XFER.
REQ-026 XFER: mem_addr = latched base + host_idx, modulo 256 (wraps 0xFF -> 0x00); mem_we = latched host_we; mem_data = host_wdata; host_ack=1; host_idx increments each cycle.
REQ-027 Last XFER cycle (host_idx = latched len): host_ack=1 and host_done=1 in the same cycle, then enter GAP.
REQ-028 Latency: host_req sampled at posedge N gives the first host_ack in cycle N+1+HOLD_CYCLES; the burst occupies exactly len+1 consecutive cycles.
REQ-029 GAP: SHALL last exactly MIN_GAP cycles, then enter IDLE; host_req SHALL be ignored in GAP.
REQ-030 host_req low during DRAIN or XFER (abort): in that cycle mem_we=0, host_ack=0 and host_done=1; next state is GAP; host_idx holds the count of words already transferred.
REQ-031 cpu_we=1 in DRAIN or XFER: the CPU write SHALL NOT reach memory, and cpu_collision SHALL set and stay set until reset.
REQ-032 cpu_rdata and host_rdata SHALL be combinational copies of mem_q.

Reset
REQ-033 reset SHALL force state IDLE, cpu_hold=0, host_ack=0, host_done=0, host_idx=0, cpu_collision=0 and all counters to 0, winning over every other event.
REQ-034 reset mid-burst SHALL abort the burst with no host_done pulse; memory ownership returns to the CPU in the next cycle.
REQ-035 After reset, a host_req SHALL be grantable immediately, with no GAP pending.

Verification
REQ-036 HOLD_CYCLES=1; host write, addr 0x10, len 3, data 0xA000+idx -> cpu_hold high cycles 1-5; acks cycles 2-5; dmem[0x10..0x13] = A000..A003; done in cycle 5.
REQ-037 host read, addr 0xFE, len 2 -> mem_addr sequence FE, FF, 00; host_rdata matches dmem at each address; no write occurs.
REQ-038 back-to-back host_req held high -> second grant no earlier than MIN_GAP=4 cycles after host_done; CPU writes land during GAP.
REQ-039 cpu_we=1 with cpu_addr 0x20 during XFER -> dmem[0x20] unchanged; cpu_collision=1 until reset.
REQ-040 host_req dropped after 2 acks of a 16-word burst -> done pulse, host_idx=2, GAP entered, dmem beyond the second word untouched.
REQ-041 reset asserted during XFER -> next cycle IDLE with cpu_hold=0 and no host_done; a host_req issued immediately afterwards is granted.
